// File: rtl/mbus_rx_pkg.sv
// Shared types for the mbus layer RX front end: FIFO entry layout,
// handshake FSM state encoding and the legal synchroniser depth range.
package mbus_rx_pkg;

    // Widest address/data an entry can carry; the front end zero-extends
    // narrower buses into these fields and truncates on the way out.
    localparam int RX_ADDR_W = 32;
    localparam int RX_DATA_W = 32;

    // Legal range of the NODE_RX_REQ / NODE_TX_ACK synchroniser depth.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef struct packed {
        logic [RX_ADDR_W-1:0] addr;
        logic [RX_DATA_W-1:0] data;
        logic                 broadcast;
        logic                 pend;
        logic                 fail;
    } rx_entry_t;

    typedef enum logic [1:0] {
        RX_IDLE       = 2'd0,
        RX_DECIDE     = 2'd1,
        RX_WAIT_SPACE = 2'd2,
        RX_ACK        = 2'd3
    } rx_state_e;

    // Keep an out-of-range synchroniser depth inside the supported range.
    function automatic int clamp_sync_stages(input int n);
        if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/mbus_layer_rx_frontend_if.sv
// Node-side RX handshake and host-side RX stream of the layer front end.
// slave: the front end itself; master: the node/host environment.
interface mbus_layer_rx_frontend_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  NODE_RX_REQ;
    logic [ADDR_WIDTH-1:0] NODE_RX_ADDR;
    logic [DATA_WIDTH-1:0] NODE_RX_DATA;
    logic                  NODE_RX_BROADCAST;
    logic                  NODE_RX_PEND;
    logic                  NODE_RX_FAIL;
    logic                  NODE_RX_ACK;

    logic                  HOST_RX_VALID;
    logic                  HOST_RX_READY;
    logic [ADDR_WIDTH-1:0] HOST_RX_ADDR;
    logic [DATA_WIDTH-1:0] HOST_RX_DATA;
    logic                  HOST_RX_BROADCAST;
    logic                  HOST_RX_PEND;
    logic                  HOST_RX_FAIL;

    modport slave (
        input  NODE_RX_REQ, NODE_RX_ADDR, NODE_RX_DATA,
        input  NODE_RX_BROADCAST, NODE_RX_PEND, NODE_RX_FAIL,
        output NODE_RX_ACK,
        output HOST_RX_VALID, HOST_RX_ADDR, HOST_RX_DATA,
        output HOST_RX_BROADCAST, HOST_RX_PEND, HOST_RX_FAIL,
        input  HOST_RX_READY
    );

    modport master (
        output NODE_RX_REQ, NODE_RX_ADDR, NODE_RX_DATA,
        output NODE_RX_BROADCAST, NODE_RX_PEND, NODE_RX_FAIL,
        input  NODE_RX_ACK,
        input  HOST_RX_VALID, HOST_RX_ADDR, HOST_RX_DATA,
        input  HOST_RX_BROADCAST, HOST_RX_PEND, HOST_RX_FAIL,
        output HOST_RX_READY
    );
endinterface

// File: rtl/mbus_rx_fifo.sv
// Synchronous FIFO of rx_entry_t. The head entry is held in a register so
// it keeps the last value shown once the FIFO drains.
module mbus_rx_fifo
    import mbus_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  rx_entry_t              push_data_i,
    input  logic                   pop_i,
    output rx_entry_t              head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    rx_entry_t         mem_q [DEPTH];
    rx_entry_t         head_q, head_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              push_en, pop_en;

    // Qualify push/pop against the registered level and work out the next head.
    always_comb begin
        push_en  = push_i && (level_q != LW'(DEPTH));
        pop_en   = pop_i && (level_q != '0);
        level_d  = level_q + LW'(push_en) - LW'(pop_en);
        rd_ptr_d = rd_ptr_q + PW'(pop_en);
        head_d   = head_q;
        if (level_d != '0) begin
            // Nothing left behind the popped entry: the new head is the word being pushed.
            if ((level_q - LW'(pop_en)) == '0) head_d = push_data_i;
            else                               head_d = mem_q[rd_ptr_d];
        end
    end

    // Pointers, level and head register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // Entry storage; contents are only meaningful behind a valid pointer.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = head_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/mbus_layer_rx_frontend.sv
// CLK_EXT-domain front end between mbus_node RX/TX-ack and the layer host.
// Synchronises RX_REQ / TX_ACK, drops broadcast words on masked channels
// (auto-acked) and queues the rest so the node is released early.
// Optional build macro MBUS_RX_STATS_EN adds filter/stall counters.
module mbus_layer_rx_frontend
    import mbus_rx_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int FUNC_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          CLK_EXT,
    input  logic                          RESET,
    input  logic                          MASTER_EN,
    input  logic [2**FUNC_WIDTH-1:0]      FILTER_MASK,
    input  logic                          NODE_TX_ACK,
    output logic                          TX_ACK,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
`ifdef MBUS_RX_STATS_EN
    input  logic                          STATS_CLR,
    output logic [15:0]                   FILTER_CNT,
    output logic [15:0]                   STALL_CNT,
`endif
    mbus_layer_rx_frontend_if.slave       bus
);
    localparam int SYNC_N = clamp_sync_stages(SYNC_STAGES);

    localparam logic [1:0] ST_IDLE       = RX_IDLE;
    localparam logic [1:0] ST_DECIDE     = RX_DECIDE;
    localparam logic [1:0] ST_WAIT_SPACE = RX_WAIT_SPACE;
    localparam logic [1:0] ST_ACK        = RX_ACK;

    logic [SYNC_N-1:0] req_sync_q;
    logic [SYNC_N-1:0] txa_sync_q;
    logic              req_s;

    logic [1:0]        state_q, state_d;
    logic              ack_q, ack_d;
    logic              push;
    logic              drop;
    logic              drop_evt;
    logic              stall_evt;

    rx_entry_t         in_entry;
    rx_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;

    // Counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Two independent flop chains for the asynchronous node strobes.
    always_ff @(posedge CLK_EXT) begin
        if (RESET) begin
            req_sync_q <= '0;
            txa_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_N-2:0], bus.NODE_RX_REQ};
            txa_sync_q <= {txa_sync_q[SYNC_N-2:0], NODE_TX_ACK};
        end
    end

    assign req_s  = req_sync_q[SYNC_N-1];
    assign TX_ACK = txa_sync_q[SYNC_N-1];

    // FAIL words always reach the host so failures are never hidden.
    assign drop = MASTER_EN & bus.NODE_RX_BROADCAST & ~bus.NODE_RX_FAIL &
                  FILTER_MASK[bus.NODE_RX_ADDR[FUNC_WIDTH-1:0]];

    assign in_entry.addr      = RX_ADDR_W'(bus.NODE_RX_ADDR);
    assign in_entry.data      = RX_DATA_W'(bus.NODE_RX_DATA);
    assign in_entry.broadcast = bus.NODE_RX_BROADCAST;
    assign in_entry.pend      = bus.NODE_RX_PEND;
    assign in_entry.fail      = bus.NODE_RX_FAIL;

    // Four-phase handshake: decide drop/push, stall while full, wait for req release.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        push      = 1'b0;
        drop_evt  = 1'b0;
        stall_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (drop) begin
                    drop_evt = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ST_ACK;
                end else if (!fifo_full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                stall_evt = 1'b1;
                if (!fifo_full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake state and registered ack.
    always_ff @(posedge CLK_EXT) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.NODE_RX_ACK = ack_q;

    mbus_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLK_EXT),
        .rst_i       (RESET),
        .push_i      (push),
        .push_data_i (in_entry),
        .pop_i       (bus.HOST_RX_READY),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (FIFO_LEVEL)
    );

    assign bus.HOST_RX_VALID     = ~fifo_empty;
    assign bus.HOST_RX_ADDR      = head.addr[ADDR_WIDTH-1:0];
    assign bus.HOST_RX_DATA      = head.data[DATA_WIDTH-1:0];
    assign bus.HOST_RX_BROADCAST = head.broadcast;
    assign bus.HOST_RX_PEND      = head.pend;
    assign bus.HOST_RX_FAIL      = head.fail;

`ifdef MBUS_RX_STATS_EN
    logic [15:0] filter_cnt_q;
    logic [15:0] stall_cnt_q;

    // Saturating statistics; STATS_CLR wins over a same-cycle increment.
    always_ff @(posedge CLK_EXT) begin
        if (RESET || STATS_CLR) begin
            filter_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (drop_evt)  filter_cnt_q <= sat_inc16(filter_cnt_q);
            if (stall_evt) stall_cnt_q  <= sat_inc16(stall_cnt_q);
        end
    end

    assign FILTER_CNT = filter_cnt_q;
    assign STALL_CNT  = stall_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{drop_evt, stall_evt, sat_inc16(16'h0000)};
`endif

endmodule

// File: tb/tb_mbus_layer_rx_frontend.sv
// Testbench for mbus_layer_rx_frontend (SYNC_STAGES=3, FIFO_DEPTH=4).
module tb_mbus_layer_rx_frontend;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FW = 4;
    localparam int SS = 3;
    localparam int FD = 4;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          men = 1'b0;
    logic [15:0]   mask = '0;
    logic          ntx = 1'b0;
    logic          tx_ack;
    logic [LW-1:0] level;
`ifdef MBUS_RX_STATS_EN
    logic          sclr = 1'b0;
    logic [15:0]   fcnt;
    logic [15:0]   scnt;
`endif

    int checks = 0;
    int failures = 0;
    int exp_filter = 0;
    bit drv_done = 0;
    logic [31:0] last_a = '0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        bc;
        logic        pd;
        logic        fl;
    } ent_t;
    ent_t exp_q[$];

    typedef struct {
        logic        men;
        logic [15:0] mask;
        logic [31:0] addr;
        logic [31:0] data;
        logic        bc;
        logic        pd;
        logic        fl;
        logic        exp_push;
    } vec_t;
    vec_t vt[6];

    mbus_layer_rx_frontend_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mbus_layer_rx_frontend #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FUNC_WIDTH (FW),
        .SYNC_STAGES(SS),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLK_EXT     (clk),
        .RESET       (rst),
        .MASTER_EN   (men),
        .FILTER_MASK (mask),
        .NODE_TX_ACK (ntx),
        .TX_ACK      (tx_ack),
        .FIFO_LEVEL  (level),
`ifdef MBUS_RX_STATS_EN
        .STATS_CLR   (sclr),
        .FILTER_CNT  (fcnt),
        .STALL_CNT   (scnt),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, input int bound, output int n);
        n = 0;
        while (bus.NODE_RX_ACK !== val && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] d,
                            input logic bc, input logic pd, input logic fl);
        bus.NODE_RX_ADDR      = a;
        bus.NODE_RX_DATA      = d;
        bus.NODE_RX_BROADCAST = bc;
        bus.NODE_RX_PEND      = pd;
        bus.NODE_RX_FAIL      = fl;
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d,
                             input logic bc, input logic pd, input logic fl, input string nm);
        int n;
        tick();
        set_word(a, d, bc, pd, fl);
        bus.NODE_RX_REQ = 1'b1;
        wait_ack(1'b1, 300, n);
        chk({nm, "_ack"}, bus.NODE_RX_ACK, 1);
        bus.NODE_RX_REQ = 1'b0;
        wait_ack(1'b0, 300, n);
        chk({nm, "_release"}, bus.NODE_RX_ACK, 0);
    endtask

    task automatic pop_one();
        bus.HOST_RX_READY = 1'b1;
        tick();
        bus.HOST_RX_READY = 1'b0;
    endtask

    initial begin
        int n;
        bus.NODE_RX_REQ   = 1'b0;
        bus.HOST_RX_READY = 1'b0;
        set_word('0, '0, 1'b0, 1'b0, 1'b0);

        vt[0] = '{1'b1, 16'h0001, 32'h0000_0010, 32'hD000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 16'h0001, 32'h0000_0010, 32'hD000_0001, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b1, 16'h0001, 32'h0000_0020, 32'hD000_0002, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[3] = '{1'b1, 16'h0001, 32'h0000_0031, 32'hD000_0003, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b1, 16'hFFFF, 32'h0000_0045, 32'hD000_0004, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 16'h8000, 32'hABCD_005F, 32'hD000_0005, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_node_ack", bus.NODE_RX_ACK, 0);
        chk("rst_tx_ack", tx_ack, 0);
        chk("rst_valid", bus.HOST_RX_VALID, 0);
        chk("rst_level", level, 0);
        chk("rst_host_addr", bus.HOST_RX_ADDR, 0);
        chk("rst_host_data", bus.HOST_RX_DATA, 0);
`ifdef MBUS_RX_STATS_EN
        chk("rst_filter_cnt", fcnt, 0);
        chk("rst_stall_cnt", scnt, 0);
`endif
        rst = 1'b0;
        tick();

        // Handshake latency
        set_word(32'h0000_0100, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        bus.NODE_RX_REQ = 1'b1;
        wait_ack(1'b1, 50, n);
        chk("req_rise_to_ack_cycles", n, SS + 2);
        bus.NODE_RX_REQ = 1'b0;
        wait_ack(1'b0, 50, n);
        chk("req_fall_to_ack_fall_cycles", n, SS + 1);
        chk("lat_word_valid", bus.HOST_RX_VALID, 1);
        chk("lat_word_addr", bus.HOST_RX_ADDR, 32'h0000_0100);
        pop_one();

        // TX_ACK latency, both edges
        ntx = 1'b1;
        n = 0;
        while (tx_ack !== 1'b1 && n < 20) begin tick(); n++; end
        chk("tx_ack_rise_cycles", n, SS);
        ntx = 1'b0;
        n = 0;
        while (tx_ack !== 1'b0 && n < 20) begin tick(); n++; end
        chk("tx_ack_fall_cycles", n, SS);

        // Filter vectors
        for (int i = 0; i < 6; i++) begin
            men  = vt[i].men;
            mask = vt[i].mask;
            send_word(vt[i].addr, vt[i].data, vt[i].bc, vt[i].pd, vt[i].fl, $sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d_level", i), level, vt[i].exp_push ? 1 : 0);
            chk($sformatf("vec%0d_valid", i), bus.HOST_RX_VALID, vt[i].exp_push);
            if (!vt[i].exp_push) exp_filter++;
`ifdef MBUS_RX_STATS_EN
            chk($sformatf("vec%0d_filter_cnt", i), fcnt, exp_filter);
`endif
            if (vt[i].exp_push) begin
                chk($sformatf("vec%0d_addr", i), bus.HOST_RX_ADDR, vt[i].addr);
                chk($sformatf("vec%0d_data", i), bus.HOST_RX_DATA, vt[i].data);
                chk($sformatf("vec%0d_bcast", i), bus.HOST_RX_BROADCAST, vt[i].bc);
                chk($sformatf("vec%0d_pend", i), bus.HOST_RX_PEND, vt[i].pd);
                chk($sformatf("vec%0d_fail", i), bus.HOST_RX_FAIL, vt[i].fl);
                pop_one();
                chk($sformatf("vec%0d_level_after_pop", i), level, 0);
                chk($sformatf("vec%0d_hold_addr", i), bus.HOST_RX_ADDR, vt[i].addr);
            end
        end

        // FIFO full: fifth word stalls until one pop frees space
        men = 1'b0;
        for (int k = 1; k <= 4; k++)
            send_word(k, 32'hE000_0000 + k, 1'b0, 1'b0, 1'b0, $sformatf("fill%0d", k));
        chk("full_level", level, 4);
        tick();
        set_word(32'd5, 32'hE000_0005, 1'b0, 1'b0, 1'b0);
        bus.NODE_RX_REQ = 1'b1;
        repeat (30) tick();
        chk("stall_ack_low", bus.NODE_RX_ACK, 0);
        chk("stall_level", level, 4);
        chk("stall_head_addr", bus.HOST_RX_ADDR, 1);
        pop_one();
        wait_ack(1'b1, 20, n);
        chk("stall_release_ack", bus.NODE_RX_ACK, 1);
        chk("stall_release_level", level, 4);
        bus.NODE_RX_REQ = 1'b0;
        wait_ack(1'b0, 50, n);
`ifdef MBUS_RX_STATS_EN
        chk("stall_cnt_nonzero", scnt != 0, 1);
`endif
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("order_addr%0d", k), bus.HOST_RX_ADDR, k);
            chk($sformatf("order_data%0d", k), bus.HOST_RX_DATA, 32'hE000_0000 + k);
            pop_one();
        end
        chk("drain_level", level, 0);
        chk("drain_valid", bus.HOST_RX_VALID, 0);

`ifdef MBUS_RX_STATS_EN
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("stats_clr_filter", fcnt, 0);
        chk("stats_clr_stall", scnt, 0);
`endif
        exp_filter = 0;

        // Reset while in ACK with two entries queued
        send_word(32'h0000_00A1, 32'h1, 1'b0, 1'b0, 1'b0, "pre_rst");
        tick();
        set_word(32'h0000_00A2, 32'h2, 1'b0, 1'b0, 1'b0);
        bus.NODE_RX_REQ = 1'b1;
        wait_ack(1'b1, 50, n);
        chk("midrst_level_before", level, 2);
        rst = 1'b1;
        tick();
        chk("midrst_ack", bus.NODE_RX_ACK, 0);
        chk("midrst_level", level, 0);
        chk("midrst_valid", bus.HOST_RX_VALID, 0);
        rst = 1'b0;
        wait_ack(1'b1, 50, n);
        chk("midrst_restart_ack", bus.NODE_RX_ACK, 1);
        chk("midrst_restart_level", level, 1);
        chk("midrst_restart_addr", bus.HOST_RX_ADDR, 32'h0000_00A2);
        bus.NODE_RX_REQ = 1'b0;
        wait_ack(1'b0, 50, n);
        pop_one();
        chk("midrst_final_level", level, 0);

        // Randomised traffic against a queue model
        fork
            begin : driver
                for (int k = 0; k < 40; k++) begin
                    ent_t e;
                    logic m;
                    logic [15:0] mk;
                    e.a  = $urandom;
                    e.d  = $urandom;
                    e.bc = 1'($urandom_range(0, 1));
                    e.pd = 1'($urandom_range(0, 1));
                    e.fl = ($urandom_range(0, 3) == 0);
                    m    = ($urandom_range(0, 3) != 0);
                    mk   = 16'($urandom);
                    men  = m;
                    mask = mk;
                    if (m && e.bc && !e.fl && mk[e.a[3:0]]) exp_filter++;
                    else exp_q.push_back(e);
                    send_word(e.a, e.d, e.bc, e.pd, e.fl, $sformatf("rnd%0d", k));
                end
                drv_done = 1;
            end
            begin : popper
                bit done_ok = 0;
                for (int c = 0; c < 20000; c++) begin
                    @(posedge clk);
                    #1;
                    bus.HOST_RX_READY = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (bus.HOST_RX_VALID && bus.HOST_RX_READY) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rnd_pop_unexpected actual=%0h required=none", bus.HOST_RX_ADDR);
                        end else begin
                            ent_t x;
                            x = exp_q.pop_front();
                            chk("rnd_addr", bus.HOST_RX_ADDR, x.a);
                            chk("rnd_data", bus.HOST_RX_DATA, x.d);
                            chk("rnd_flags", {bus.HOST_RX_BROADCAST, bus.HOST_RX_PEND, bus.HOST_RX_FAIL},
                                {x.bc, x.pd, x.fl});
                            last_a = x.a;
                        end
                    end
                    if (drv_done && exp_q.size() == 0) begin
                        done_ok = 1;
                        break;
                    end
                end
                chk("rnd_drain_in_time", done_ok, 1);
                @(posedge clk);
                #1;
                bus.HOST_RX_READY = 1'b0;
            end
        join
        repeat (3) tick();
        chk("rnd_final_level", level, 0);
        chk("rnd_final_valid", bus.HOST_RX_VALID, 0);
        chk("rnd_hold_last_addr", bus.HOST_RX_ADDR, last_a);
`ifdef MBUS_RX_STATS_EN
        chk("rnd_filter_cnt", fcnt, exp_filter);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
